hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO register pair of the MIPS datapath (MULT/MULTU/DIV/DIVU, MTHI/MTLO).

---
 rtl/hilo_muldiv_unit_pkg.sv | 28 ++
 rtl/hilo_muldiv_unit_iter_step.sv | 36 +++
 rtl/hilo_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_step.sv
// One iteration of the shared multiply/divide datapath, purely combinational.
// Multiply: acc = {partial_hi, multiplier}; add multiplicand on lsb, shift right.
// Divide:   acc = {remainder, dividend/quotient}; restoring shift-subtract, shift left.
module muldiv_iter_step
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Compute both candidate updates and select by operation class.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      // A borrow out of the top bit means the trial subtract went negative: restore.
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// IDLE -> RUN (WIDTH iterations) -> FIX (sign fix + HI/LO write) -> IDLE.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WriteHi,
  input  logic             WriteLo,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH);

  // Magnitude of a possibly signed operand.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  // Conditional two's-complement negate of a result half.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Control state (reset).
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Datapath state (loaded on Start, not reset).
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               zero_div_q, zero_div_d;

  op_e                op_in;
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_fixed;

  assign op_in     = op_e'(Op);
  assign op_signed = op_is_signed(op_in);
  assign a_abs     = abs_val(A, op_signed);
  assign b_abs     = abs_val(B, op_signed);
  assign prod_fixed = neg_lo_q ? -acc_q : acc_q;

  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  // Next-state, datapath load/iterate and HI/LO update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    zero_div_d = zero_div_q;

    unique case (state_q)
      ST_IDLE: begin
        if (WriteHi) hi_d = WriteData;
        if (WriteLo) lo_d = WriteData;
        if (Start) begin
          is_div_d   = op_is_div(op_in);
          neg_lo_d   = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_hi_d   = op_signed && A[WIDTH-1];
          zero_div_d = op_is_div(op_in) && (B == '0);
          cnt_d      = '0;
          if (op_is_div(op_in)) begin
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_abs};
            opnd_d = a_abs;
          end
          state_d = (op_is_div(op_in) && (B == '0)) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        if (!zero_div_q) begin
          if (is_div_q) begin
            lo_d = cond_neg(acc_q[WIDTH-1:0], neg_lo_q);
            hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          end else begin
            {hi_d, lo_d} = prod_fixed;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Datapath registers; always loaded on Start before being read.
  always_ff @(posedge Clk) begin
    // NOTE: these are deliberately not reset: the FSM never reads them before a Start load.
    acc_q      <= acc_d;
    opnd_q     <= opnd_d;
    is_div_q   <= is_div_d;
    neg_lo_q   <= neg_lo_d;
    neg_hi_q   <= neg_hi_d;
    zero_div_q <= zero_div_d;
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit (WIDTH = 32).
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        write_hi, write_lo;
  logic [31:0] write_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_vec  = 0;
  int n_miss = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Start     (start),
    .Op        (op),
    .A         (a),
    .B         (b),
    .WriteHi   (write_hi),
    .WriteLo   (write_lo),
    .WriteData (write_data),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (div_by_zero),
    .Hi        (hi),
    .Lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  // Edges after the Start edge until Done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    #1;
    tick(); tick();
    reset = 1'b0;
    check("rst_hi",   hi, 0);
    check("rst_lo",   lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz",  div_by_zero, 0);

    // MULTU max*max: latency, result, one-cycle Done.
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(n);
    check("multu_lat", n, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_busy_end", busy, 0);
    tick();
    check("multu_done_pulse", done, 0);

    // MULT -3 * 7 = -21.
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(n);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // DIV -7 / 2 = -3 rem -1.
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 0: fast Done + DivByZero, HI/LO untouched.
    start_op(2'b11, 32'd100, 32'd0);
    check("dbz_done_early", done, 0);
    wait_done(n);
    check("dbz_lat", n, 1);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_hi", hi, 32'hFFFF_FFFF);
    check("dbz_lo", lo, 32'hFFFF_FFFD);
    tick();
    check("dbz_pulse_done", done, 0);
    check("dbz_pulse_flag", div_by_zero, 0);

    // DIV most-negative / -1 wraps without trap.
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);
    check("divovf_dbz", div_by_zero, 0);

    // DIV 7 / -2 = -3 rem 1 (remainder follows dividend).
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done(n);
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'h1);

    // MULTU with a carry into HI.
    start_op(2'b01, 32'h1234_5678, 32'h10);
    wait_done(n);
    check("multu2_hi", hi, 32'h1);
    check("multu2_lo", lo, 32'h2345_6780);

    // MULT 5*6 with a second Start and a WriteLo at cycle 10, both ignored.
    start_op(2'b00, 32'd5, 32'd6);
    for (int i = 1; i < 10; i++) tick();
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd7;
    write_lo = 1'b1; write_data = 32'hDEAD;
    tick();
    start = 1'b0; write_lo = 1'b0;
    check("busy_wlo_lo", lo, 32'h2345_6780);
    wait_done(n);
    check("ignore_lat", n + 10, 33);
    check("ignore_hi", hi, 32'h0);
    check("ignore_lo", lo, 32'h1E);
    tick();
    check("ignore_no_queue", busy, 0);

    // DIVU 1000 / 7 = 142 rem 6.
    start_op(2'b11, 32'd1000, 32'd7);
    wait_done(n);
    check("divu_lo", lo, 32'd142);
    check("divu_hi", hi, 32'd6);

    // MTLO in IDLE.
    write_lo = 1'b1; write_data = 32'hCAFE;
    tick();
    write_lo = 1'b0;
    check("mtlo", lo, 32'hCAFE);

    // Reset at cycle 15 of a DIVU aborts with no Done.
    start_op(2'b11, 32'd1000, 32'd7);
    for (int i = 1; i < 15; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);

    // WriteHi together with Start: write now, product later.
    write_hi = 1'b1; write_data = 32'h1234;
    start_op(2'b01, 32'd2, 32'd3);
    write_hi = 1'b0;
    check("wh_start_hi", hi, 32'h1234);
    wait_done(n);
    check("wh_start_lat", n, 33);
    check("wh_res_hi", hi, 32'h0);
    check("wh_res_lo", lo, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
